// File: rtl/uart_rx.sv
// 8N1 UART receiver: 2-flop synchronized input, mid-bit sampling, valid/ready
// byte output with one-cycle frame-error and overrun pulses.
module uart_rx #(
  parameter int unsigned CLOCK_RATE = 24000000,
  parameter int unsigned BAUD_RATE  = 1200
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       ser_rx,
  output logic [7:0] o_data,
  output logic       o_valid,
  input  logic       i_ready,
  output logic       o_frame_err,
  output logic       o_overrun,
  output logic       o_busy
);

  localparam int unsigned CLKS_PER_BIT = CLOCK_RATE / BAUD_RATE;
  localparam int unsigned HALF_BIT     = CLKS_PER_BIT / 2;
  localparam int unsigned CNT_W        = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF_BIT - 1);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  logic             rx_meta;
  logic             rx_s;
  logic             rx_prev;
  logic [1:0]       settle;
  logic             fall_c;

  state_t           state;
  state_t           state_next;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_next;
  logic [2:0]       idx;
  logic [2:0]       idx_next;
  logic [7:0]       shift;
  logic [7:0]       shift_next;
  logic             deliver_c;
  logic             stop_bad_c;

  logic [7:0]       data_next;
  logic             valid_next;
  logic             frame_err_next;
  logic             overrun_next;

  // Synchronizer; rx_prev only reflects the real line once the reset
  // values have flushed out, so a line held low across reset never
  // looks like a start edge.
  always_ff @(posedge clock) begin
    if (reset) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
      rx_prev <= 1'b0;
      settle  <= 2'b00;
    end else begin
      rx_meta <= ser_rx;
      rx_s    <= rx_meta;
      settle  <= {settle[0], 1'b1};
      rx_prev <= rx_s & settle[1];
    end
  end

  assign fall_c = rx_prev & ~rx_s;

  // State register
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
      idx   <= '0;
      shift <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
      idx   <= idx_next;
      shift <= shift_next;
    end
  end

  // Next-state: bit timing, sampling and frame completion
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    idx_next   = idx;
    shift_next = shift;
    deliver_c  = 1'b0;
    stop_bad_c = 1'b0;
    case (state)
      IDLE: begin
        cnt_next = '0;
        idx_next = '0;
        if (fall_c) state_next = START;
      end
      START: begin
        if (cnt == HALF_LAST) begin
          cnt_next = '0;
          idx_next = '0;
          state_next = rx_s ? IDLE : DATA;
        end else begin
          cnt_next = cnt + CNT_W'(1);
        end
      end
      DATA: begin
        if (cnt == BIT_LAST) begin
          cnt_next        = '0;
          shift_next[idx] = rx_s;
          if (idx == 3'd7) state_next = STOP;
          else             idx_next   = idx + 3'd1;
        end else begin
          cnt_next = cnt + CNT_W'(1);
        end
      end
      STOP: begin
        if (cnt == BIT_LAST) begin
          cnt_next   = '0;
          state_next = IDLE;
          deliver_c  = rx_s;
          stop_bad_c = ~rx_s;
        end else begin
          cnt_next = cnt + CNT_W'(1);
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Output next-values: handshake, delivery, overrun and frame error
  always_comb begin
    data_next      = o_data;
    valid_next     = o_valid;
    frame_err_next = 1'b0;
    overrun_next   = 1'b0;
    if (o_valid && i_ready) valid_next = 1'b0;
    if (deliver_c) begin
      if (o_valid && !i_ready) begin
        overrun_next = 1'b1;
      end else begin
        data_next  = shift;
        valid_next = 1'b1;
      end
    end
    if (stop_bad_c) frame_err_next = 1'b1;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      o_data      <= 8'h00;
      o_valid     <= 1'b0;
      o_frame_err <= 1'b0;
      o_overrun   <= 1'b0;
      o_busy      <= 1'b0;
    end else begin
      o_data      <= data_next;
      o_valid     <= valid_next;
      o_frame_err <= frame_err_next;
      o_overrun   <= overrun_next;
      o_busy      <= (state_next != IDLE);
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx at 16 clocks per bit.
module tb_uart_rx;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       ser_rx = 1'b1;
  logic [7:0] o_data;
  logic       o_valid;
  logic       i_ready = 1'b0;
  logic       o_frame_err;
  logic       o_overrun;
  logic       o_busy;

  int n_checks = 0;
  int n_errors = 0;
  int ferr_cycles = 0;
  int ovr_cycles = 0;
  logic [7:0] xfer_q[$];

  uart_rx #(.CLOCK_RATE(16), .BAUD_RATE(1)) dut (
    .clock      (clock),
    .reset      (reset),
    .ser_rx     (ser_rx),
    .o_data     (o_data),
    .o_valid    (o_valid),
    .i_ready    (i_ready),
    .o_frame_err(o_frame_err),
    .o_overrun  (o_overrun),
    .o_busy     (o_busy)
  );

  always #5 clock = ~clock;

  // Pulse-width counters and transfer log
  always @(posedge clock) begin
    if (!reset) begin
      if (o_frame_err) ferr_cycles++;
      if (o_overrun) ovr_cycles++;
      if (o_valid && i_ready) xfer_q.push_back(o_data);
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input int n);
    ser_rx = v;
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop_v);
    drive(1'b0, 16);
    for (int i = 0; i < 8; i++) drive(b[i], 16);
    drive(stop_v, 16);
  endtask

  task automatic pulse_ready();
    i_ready = 1'b1;
    @(posedge clock);
    #1;
    i_ready = 1'b0;
  endtask

  initial begin
    // Reset state
    repeat (3) @(posedge clock);
    #1;
    check("rst_data", 32'(o_data), 32'h00);
    check("rst_valid", 32'(o_valid), 32'h0);
    check("rst_ferr", 32'(o_frame_err), 32'h0);
    check("rst_ovr", 32'(o_overrun), 32'h0);
    check("rst_busy", 32'(o_busy), 32'h0);
    reset = 1'b0;
    drive(1'b1, 8);

    // Clean frame held until consumed
    send_frame(8'h55, 1'b1);
    drive(1'b1, 20);
    check("f55_data", 32'(o_data), 32'h55);
    check("f55_valid", 32'(o_valid), 32'h1);
    check("f55_busy", 32'(o_busy), 32'h0);
    pulse_ready();
    check("f55_consumed", 32'(o_valid), 32'h0);
    check("f55_data_kept", 32'(o_data), 32'h55);

    // Short glitch is a false start
    drive(1'b0, 4);
    check("glitch_busy_hi", 32'(o_busy), 32'h1);
    drive(1'b1, 12);
    check("glitch_busy_lo", 32'(o_busy), 32'h0);
    check("glitch_valid", 32'(o_valid), 32'h0);
    drive(1'b1, 20);
    check("glitch_ferr", 32'(ferr_cycles), 32'd0);

    // Bad stop bit, then line held low
    send_frame(8'hA5, 1'b0);
    drive(1'b0, 40);
    check("ferr_pulse", 32'(ferr_cycles), 32'd1);
    check("ferr_valid", 32'(o_valid), 32'h0);
    check("ferr_data", 32'(o_data), 32'h55);
    check("ferr_no_restart", 32'(o_busy), 32'h0);
    drive(1'b1, 20);
    send_frame(8'h96, 1'b1);
    drive(1'b1, 4);
    check("after_ferr_data", 32'(o_data), 32'h96);
    check("after_ferr_valid", 32'(o_valid), 32'h1);
    pulse_ready();

    // Back-to-back with no consumer: overrun
    send_frame(8'h11, 1'b1);
    send_frame(8'h22, 1'b1);
    drive(1'b1, 4);
    check("ovr_data", 32'(o_data), 32'h11);
    check("ovr_valid", 32'(o_valid), 32'h1);
    check("ovr_pulse", 32'(ovr_cycles), 32'd1);
    pulse_ready();
    check("ovr_consumed", 32'(o_valid), 32'h0);

    // Back-to-back with consumer always ready
    xfer_q.delete();
    i_ready = 1'b1;
    send_frame(8'h11, 1'b1);
    send_frame(8'h22, 1'b1);
    drive(1'b1, 4);
    i_ready = 1'b0;
    check("rdy_count", 32'(xfer_q.size()), 32'd2);
    if (xfer_q.size() == 2) begin
      check("rdy_first", 32'(xfer_q[0]), 32'h11);
      check("rdy_second", 32'(xfer_q[1]), 32'h22);
    end
    check("rdy_no_ovr", 32'(ovr_cycles), 32'd1);
    check("rdy_valid", 32'(o_valid), 32'h0);

    // Reset during data bit 3 of 0xF0
    drive(1'b0, 16);
    for (int i = 0; i < 3; i++) drive(1'b0, 16);
    drive(1'b0, 8);
    check("mid_busy", 32'(o_busy), 32'h1);
    reset = 1'b1;
    @(posedge clock);
    #1;
    reset = 1'b0;
    check("mid_rst_data", 32'(o_data), 32'h00);
    check("mid_rst_valid", 32'(o_valid), 32'h0);
    check("mid_rst_busy", 32'(o_busy), 32'h0);
    drive(1'b0, 7);
    drive(1'b1, 64);
    drive(1'b1, 16);
    drive(1'b1, 20);
    check("tail_ignored_valid", 32'(o_valid), 32'h0);
    check("tail_ignored_busy", 32'(o_busy), 32'h0);
    check("tail_ignored_ferr", 32'(ferr_cycles), 32'd1);
    send_frame(8'h3C, 1'b1);
    drive(1'b1, 4);
    check("f3c_data", 32'(o_data), 32'h3C);
    check("f3c_valid", 32'(o_valid), 32'h1);
    check("f3c_no_ovr", 32'(ovr_cycles), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 SHALL have parameter CLOCK_RATE, default 24000000, meaning the clock frequency in Hz.
REQ-002 SHALL have parameter BAUD_RATE, default 1200, meaning the serial bit rate in bits/s.
REQ-003 SHALL derive CLKS_PER_BIT = CLOCK_RATE/BAUD_RATE (integer) and HALF_BIT = CLKS_PER_BIT/2 (integer); CLKS_PER_BIT < 4 is unsupported.
REQ-004 SHALL have port clock, input, 1, the single clock; all logic is on its rising edge.
REQ-005 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-006 SHALL have port ser_rx, input, 1, the asynchronous serial line, idle high.
REQ-007 SHALL have port o_data, output, 8, the last received byte.
REQ-008 SHALL have port o_valid, output, 1, meaning o_data holds an unconsumed byte.
REQ-009 SHALL have port i_ready, input, 1, meaning the consumer accepts o_data.
REQ-010 SHALL have port o_frame_err, output, 1, a one-cycle pulse on a bad stop bit.
REQ-011 SHALL have port o_overrun, output, 1, a one-cycle pulse when a byte is dropped.
REQ-012 SHALL have port o_busy, output, 1, high whenever the FSM is not in IDLE.

Function
REQ-013 SHALL pass ser_rx through a 2-flop synchronizer; rx_s is the second flop; both flops reset to 1.
REQ-014 SHALL implement the FSM states IDLE, START, DATA and STOP, with a bit-period counter cnt and a bit index idx of 0..7.
REQ-015 IDLE: on the first cycle rx_s==0 after a cycle with rx_s==1, SHALL move to START with cnt=0.
REQ-016 IDLE: a line held low without a preceding high SHALL NOT start a frame.
REQ-017 START: cnt SHALL increment each cycle; at cnt==HALF_BIT-1, the FSM SHALL sample rx_s.
REQ-018 START sample: if rx_s==1 (false start), the FSM SHALL return to IDLE with no output activity; otherwise it SHALL go to DATA with cnt=0 and idx=0.
REQ-019 DATA: at cnt==CLKS_PER_BIT-1, the FSM SHALL sample rx_s into shift bit idx (LSB first) and reset cnt to 0; after idx==7 is sampled it SHALL go to STOP.
REQ-020 STOP: at cnt==CLKS_PER_BIT-1, the FSM SHALL sample rx_s and return to IDLE in the same transition, with no wait for the end of the stop bit.
REQ-021 Stop sample 1: the received byte SHALL be delivered per REQ-023..REQ-025.
REQ-022 Stop sample 0: o_frame_err SHALL be 1 for exactly the next cycle, the byte SHALL be discarded, and o_valid and o_data SHALL be unchanged.
REQ-023 Delivery: o_data SHALL update and o_valid SHALL rise on the cycle after the stop sample.
REQ-024 Handshake: a transfer occurs on a cycle where o_valid && i_ready; o_valid SHALL then clear next cycle unless a new byte is delivered that same cycle.
REQ-025 Overrun: if delivery coincides with o_valid==1 && i_ready==0, the new byte SHALL be dropped, the old o_data retained, and o_overrun SHALL be 1 for one cycle.
REQ-026 Delivery coinciding with o_valid==1 && i_ready==1 SHALL load the new byte, keep o_valid=1, and SHALL NOT signal overrun.
REQ-027 o_data SHALL be stable while o_valid==1 and not transferred.
REQ-028 Counter width SHALL be $clog2(CLKS_PER_BIT) bits; cnt SHALL never exceed CLKS_PER_BIT-1.
REQ-029 Frame length from the start edge to the stop sample SHALL be HALF_BIT + 9*CLKS_PER_BIT cycles, measured from the first rx_s==0 cycle.

Reset
REQ-030 Reset SHALL force the state to IDLE, and set cnt=0, idx=0, the shift register to 0, and both synchronizer flops to 1.
REQ-031 Reset SHALL force o_data=0x00, o_valid=0, o_frame_err=0, o_overrun=0 and o_busy=0.
REQ-032 Reset asserted mid-frame SHALL abandon the frame; after release, a new frame SHALL need a fresh high-to-low edge.
REQ-033 Reset SHALL take priority over all other events in the same cycle.

Verification (CLOCK_RATE=16, BAUD_RATE=1, so CLKS_PER_BIT=16 and HALF_BIT=8)
REQ-034 Drive frame 0x55 with correct timing, i_ready=0 -> o_data=0x55 and o_valid=1 held; raise i_ready for 1 cycle -> o_valid=0 next cycle.
REQ-035 Drive a low pulse of 4 cycles, then high -> the FSM returns to IDLE, o_valid stays 0, o_busy clears by cycle 9.
REQ-036 Drive 0xA5 with stop bit 0, then hold the line low 40 cycles -> o_frame_err pulses once, o_valid stays 0, no new frame starts until the line goes high and then low.
REQ-037 Drive 0x11 then 0x22 back-to-back with i_ready=0 -> o_data=0x11 retained and o_overrun pulses once; repeat with i_ready=1 -> 0x11 then 0x22 transferred, no overrun.
REQ-038 Assert reset during DATA bit 3 of 0xF0 -> all outputs go to reset values next cycle; the remaining bits are ignored; the next clean frame 0x3C is received correctly.
